// File: rtl/iterative_shifter_if.sv
// iterative_shifter_if: request/response handshake bundle for the iterative shifter
interface iterative_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_out;
    modport master (
        output in_valid, op, data_in, shamt, out_ready,
        input  in_ready, out_valid, data_out
    );
    modport slave (
        input  in_valid, op, data_in, shamt, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle SLL/SRL/SRA/ROL unit shifting STEP bits per cycle
module iterative_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    iterative_shifter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          work_q, work_d;
    logic [WIDTH-1:0]          data_out_q, data_out_d;
    logic [1:0]                op_q, op_d;
    logic [SHAMT_W-1:0]        rem_q, rem_d;
    logic [SHAMT_W:0]          amt;
    logic                      last;
    logic signed [WIDTH-1:0]   sra;
    logic [WIDTH-1:0]          shifted;
    always_comb begin
        last       = {1'b0, rem_q} <= (SHAMT_W+1)'(STEP);
        amt        = last ? {1'b0, rem_q} : (SHAMT_W+1)'(STEP);
        // kept separate so the ternary below cannot strip the signedness
        sra        = $signed(work_q) >>> amt;
        shifted    = op_q == 2'b00 ? work_q << amt :
                     op_q == 2'b01 ? work_q >> amt :
                     op_q == 2'b10 ? sra :
                     (work_q << amt) | (work_q >> (WIDTH - int'(amt)));
        state_d    = state_q;
        work_d     = work_q;
        data_out_d = data_out_q;
        op_d       = op_q;
        rem_d      = rem_q;
        if (state_q == IDLE && bus.in_valid) begin
            state_d = BUSY;
            work_d  = bus.data_in;
            op_d    = bus.op;
            rem_d   = bus.shamt;
        end
        if (state_q == BUSY) begin
            work_d     = shifted;
            rem_d      = last ? '0 : rem_q - SHAMT_W'(STEP);
            state_d    = last ? DONE : BUSY;
            data_out_d = last ? shifted : data_out_q;
        end
        if (state_q == DONE && bus.out_ready)
            state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            data_out_q <= '0;
            op_q       <= 2'b00;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            data_out_q <= data_out_d;
            op_q       <= op_d;
            rem_q      <= rem_d;
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.data_out  = data_out_q;
endmodule
